axi_reg_bank: RTL and testbench

- AXI4-Lite slave register bank; successor to the fixed 64 x 32-bit register block.
- Parametrised in register count, data width and base address.
- Each register is individually software read/write (RW) or hardware-owned read-only (RO).
- RW contents drive the fabric; RO contents are loaded from hardware status inputs.
- Sits on the peripheral interconnect between the CPU bus and block control/status logic.

---
 rtl/axi_reg_bank.sv | 263 ++++++++++++++++++++++++++
 tb/tb_axi_reg_bank.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_reg_bank.sv
// axi_reg_bank: AXI4-Lite slave register bank with per-register RW / hardware-owned RO registers.
// Optional feature macro: AXI_REG_BANK_RO_SLVERR_EN (AXI writes to RO registers answer SLVERR).
module axi_reg_bank #(
  parameter logic [31:0]        BaseAddr  = 32'h3000_1000,
  parameter int unsigned        NumRegs   = 64,
  parameter int unsigned        DataWidth = 32,
  parameter logic [NumRegs-1:0] RoMask    = '0
) (
  input  logic                           a_clk,
  input  logic                           a_reset_n,
  // write address
  input  logic                           aw_valid,
  output logic                           aw_ready,
  input  logic [31:0]                    aw_addr,
  // write data
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [DataWidth-1:0]           w_data,
  input  logic [DataWidth/8-1:0]         w_strb,
  // write response
  output logic                           b_valid,
  input  logic                           b_ready,
  output logic [1:0]                     b_resp,
  // read address
  input  logic                           ar_valid,
  output logic                           ar_ready,
  input  logic [31:0]                    ar_addr,
  // read response
  output logic                           r_valid,
  input  logic                           r_ready,
  output logic [DataWidth-1:0]           r_data,
  output logic [1:0]                     r_resp,
  // hardware side
  output logic [NumRegs*DataWidth-1:0]   hw_regs,
  input  logic [NumRegs-1:0]             hw_wr_en,
  input  logic [NumRegs*DataWidth-1:0]   hw_wr_data
);

  localparam int unsigned StrbW     = DataWidth / 8;
  localparam int unsigned ByteShift = $clog2(StrbW);
  localparam int unsigned IdxW      = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  localparam int unsigned RegBytes  = NumRegs * StrbW;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespDecErr = 2'b11;
`ifdef AXI_REG_BANK_RO_SLVERR_EN
  localparam logic [1:0] RespSlvErr = 2'b10;
`endif

  // Address is in range when at/after the base and inside the window (no 32-bit wrap).
  function automatic logic dec_in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BaseAddr;
    return (addr >= BaseAddr) && (off < 32'(RegBytes));
  endfunction

  // Register index; sub-word address bits are dropped.
  function automatic logic [IdxW-1:0] dec_index(input logic [31:0] addr);
    logic [31:0] word;
    word = (addr - BaseAddr) >> ByteShift;
    return IdxW'(word);
  endfunction

  logic [DataWidth-1:0] r_regs [NumRegs];

  // Write-side holding buffers
  logic                 r_aw_full;
  logic                 r_aw_in;
  logic [IdxW-1:0]      r_aw_idx;
  logic                 r_w_full;
  logic [DataWidth-1:0] r_w_data;
  logic [StrbW-1:0]     r_w_strb;
  logic                 r_b_valid;
  logic [1:0]           r_b_resp;

  // Read output slot plus one skid entry
  logic                 r_rv;
  logic [DataWidth-1:0] r_rdata;
  logic [1:0]           r_rresp;
  logic                 r_sk_full;
  logic [DataWidth-1:0] r_sk_data;
  logic [1:0]           r_sk_resp;

  logic                 w_aw_in;
  logic [IdxW-1:0]      w_aw_idx;
  logic                 w_ar_in;
  logic [IdxW-1:0]      w_ar_idx;
  logic                 w_commit;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_ar_hs;
  logic                 w_ar_rdy;
  logic                 w_c_in;
  logic [IdxW-1:0]      w_c_idx;
  logic [DataWidth-1:0] w_c_data;
  logic [StrbW-1:0]     w_c_strb;
  logic                 w_c_ro;
  logic                 w_c_wr_rw;
  logic [1:0]           w_c_resp;
  logic [DataWidth-1:0] w_rd_data;
  logic [1:0]           w_rd_resp;
  logic                 w_out_free;

  assign w_aw_in  = dec_in_range(aw_addr);
  assign w_aw_idx = dec_index(aw_addr);
  assign w_ar_in  = dec_in_range(ar_addr);
  assign w_ar_idx = dec_index(ar_addr);

  // Commit when address and data are both present (buffered or arriving) and the B slot frees up.
  assign w_commit = a_reset_n & (r_aw_full | aw_valid) & (r_w_full | w_valid) &
                    (~r_b_valid | b_ready);
  assign aw_ready = a_reset_n & (~r_aw_full | w_commit);
  assign w_ready  = a_reset_n & (~r_w_full | w_commit);
  assign w_aw_hs  = aw_valid & aw_ready;
  assign w_w_hs   = w_valid & w_ready;

  // The oldest entry wins: buffer first, otherwise the beat handshaking now.
  assign w_c_in    = r_aw_full ? r_aw_in  : w_aw_in;
  assign w_c_idx   = r_aw_full ? r_aw_idx : w_aw_idx;
  assign w_c_data  = r_w_full  ? r_w_data : w_data;
  assign w_c_strb  = r_w_full  ? r_w_strb : w_strb;
  assign w_c_ro    = RoMask[w_c_idx];
  assign w_c_wr_rw = w_commit & w_c_in & ~w_c_ro;

  // Write response code for the transaction committing this cycle.
  always_comb begin
    w_c_resp = RespOkay;
    if (!w_c_in) begin
      w_c_resp = RespDecErr;
    end
`ifdef AXI_REG_BANK_RO_SLVERR_EN
    else if (w_c_ro) begin
      w_c_resp = RespSlvErr;
    end
`endif
  end

  // Read accepts while the skid entry is free; data sampled before this edge's commit lands.
  assign w_ar_rdy   = a_reset_n & ~r_sk_full;
  assign ar_ready   = w_ar_rdy;
  assign w_ar_hs    = ar_valid & w_ar_rdy;
  assign w_rd_data  = w_ar_in ? r_regs[w_ar_idx] : '0;
  assign w_rd_resp  = w_ar_in ? RespOkay : RespDecErr;
  assign w_out_free = ~r_rv | r_ready;

  // Register storage: AXI byte writes to RW registers, hardware loads to RO registers.
  always_ff @(posedge a_clk) begin
    if (!a_reset_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        if (RoMask[i]) begin
          if (hw_wr_en[i]) begin
            r_regs[i] <= hw_wr_data[i*DataWidth +: DataWidth];
          end
        end else if (w_c_wr_rw && (w_c_idx == IdxW'(i))) begin
          for (int k = 0; k < StrbW; k++) begin
            if (w_c_strb[k]) begin
              r_regs[i][k*8 +: 8] <= w_c_data[k*8 +: 8];
            end
          end
        end
      end
    end
  end

  // AW holding buffer: keeps a beat that could not commit; refills on the commit edge.
  always_ff @(posedge a_clk) begin
    if (!a_reset_n) begin
      r_aw_full <= 1'b0;
      r_aw_in   <= 1'b0;
      r_aw_idx  <= '0;
    end else begin
      if (w_commit && r_aw_full) begin
        r_aw_full <= w_aw_hs;
      end else if (w_aw_hs && !w_commit) begin
        r_aw_full <= 1'b1;
      end
      if (w_aw_hs && (r_aw_full || !w_commit)) begin
        r_aw_in  <= w_aw_in;
        r_aw_idx <= w_aw_idx;
      end
    end
  end

  // W holding buffer, same policy as AW.
  always_ff @(posedge a_clk) begin
    if (!a_reset_n) begin
      r_w_full <= 1'b0;
      r_w_data <= '0;
      r_w_strb <= '0;
    end else begin
      if (w_commit && r_w_full) begin
        r_w_full <= w_w_hs;
      end else if (w_w_hs && !w_commit) begin
        r_w_full <= 1'b1;
      end
      if (w_w_hs && (r_w_full || !w_commit)) begin
        r_w_data <= w_data;
        r_w_strb <= w_strb;
      end
    end
  end

  // B channel: response raised the cycle after commit, held until accepted.
  always_ff @(posedge a_clk) begin
    if (!a_reset_n) begin
      r_b_valid <= 1'b0;
      r_b_resp  <= 2'b00;
    end else if (w_commit) begin
      r_b_valid <= 1'b1;
      r_b_resp  <= w_c_resp;
    end else if (b_ready) begin
      r_b_valid <= 1'b0;
    end
  end

  // R channel: output slot fed from skid first to keep order, else from a new request.
  always_ff @(posedge a_clk) begin
    if (!a_reset_n) begin
      r_rv      <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_sk_full <= 1'b0;
      r_sk_data <= '0;
      r_sk_resp <= 2'b00;
    end else if (w_out_free) begin
      if (r_sk_full) begin
        r_rv      <= 1'b1;
        r_rdata   <= r_sk_data;
        r_rresp   <= r_sk_resp;
        r_sk_full <= 1'b0;
      end else if (w_ar_hs) begin
        r_rv    <= 1'b1;
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
      end else begin
        r_rv <= 1'b0;
      end
    end else if (w_ar_hs) begin
      r_sk_full <= 1'b1;
      r_sk_data <= w_rd_data;
      r_sk_resp <= w_rd_resp;
    end
  end

  // Flat view of the register contents for the fabric.
  always_comb begin
    hw_regs = '0;
    for (int i = 0; i < NumRegs; i++) begin
      hw_regs[i*DataWidth +: DataWidth] = r_regs[i];
    end
  end

  assign b_valid = r_b_valid;
  assign b_resp  = r_b_resp;
  assign r_valid = r_rv;
  assign r_data  = r_rdata;
  assign r_resp  = r_rresp;

endmodule

// File: tb/tb_axi_reg_bank.sv
// tb_axi_reg_bank: directed bench for axi_reg_bank (64 x 32-bit, register 3 hardware-owned).
module tb_axi_reg_bank;

  localparam logic [31:0] Base = 32'h3000_1000;
  localparam int unsigned N    = 64;
  localparam logic [63:0] RoM  = 64'h8;
`ifdef AXI_REG_BANK_RO_SLVERR_EN
  localparam logic [1:0]  RoResp = 2'b10;
`else
  localparam logic [1:0]  RoResp = 2'b00;
`endif

  logic              a_clk;
  logic              a_reset_n;
  logic              aw_valid, aw_ready;
  logic [31:0]       aw_addr;
  logic              w_valid, w_ready;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic              b_valid, b_ready;
  logic [1:0]        b_resp;
  logic              ar_valid, ar_ready;
  logic [31:0]       ar_addr;
  logic              r_valid, r_ready;
  logic [31:0]       r_data;
  logic [1:0]        r_resp;
  logic [N*32-1:0]   hw_regs;
  logic [N-1:0]      hw_wr_en;
  logic [N*32-1:0]   hw_wr_data;

  int          n_pass;
  int          n_total;
  logic [31:0] model [N];

  axi_reg_bank #(
    .BaseAddr (Base),
    .NumRegs  (N),
    .DataWidth(32),
    .RoMask   (RoM)
  ) dut (
    .a_clk     (a_clk),
    .a_reset_n (a_reset_n),
    .aw_valid  (aw_valid),
    .aw_ready  (aw_ready),
    .aw_addr   (aw_addr),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_strb    (w_strb),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_resp    (b_resp),
    .ar_valid  (ar_valid),
    .ar_ready  (ar_ready),
    .ar_addr   (ar_addr),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_data    (r_data),
    .r_resp    (r_resp),
    .hw_regs   (hw_regs),
    .hw_wr_en  (hw_wr_en),
    .hw_wr_data(hw_wr_data)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] hw_reg(input int i);
    return hw_regs[i*32 +: 32];
  endfunction

  function automatic logic [N*32-1:0] pack_model();
    logic [N*32-1:0] p;
    for (int i = 0; i < N; i++) p[i*32 +: 32] = model[i];
    return p;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] m;
    m = old;
    for (int k = 0; k < 4; k++) if (strb[k]) m[k*8 +: 8] = nw[k*8 +: 8];
    return m;
  endfunction

  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  // One AXI write with independent AW/W start delays; lat = cycles from AW handshake to b_valid.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp, output int lat);
    bit aw_done, w_done, got;
    int c, aw_c;
    aw_done = 0; w_done = 0; got = 0; c = 0; aw_c = 0;
    resp = 2'bxx; lat = -1;
    aw_addr = addr; w_data = data; w_strb = strb; b_ready = 1'b1;
    while (!(aw_done && w_done) && c < 20) begin
      aw_valid = !aw_done && (c >= aw_dly);
      w_valid  = !w_done && (c >= w_dly);
      @(negedge a_clk);
      if (aw_valid && aw_ready) begin aw_done = 1; aw_c = c; end
      if (w_valid && w_ready) w_done = 1;
      tick();
      c++;
    end
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    while (!got && c < 40) begin
      @(negedge a_clk);
      if (b_valid) begin got = 1; resp = b_resp; lat = c - aw_c; end
      tick();
      c++;
    end
    check("b_arrived", 64'(got), 64'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs, got;
    int c;
    hs = 0; got = 0; c = 0; data = 'x; resp = 2'bxx;
    ar_addr = addr; ar_valid = 1'b1; r_ready = 1'b1;
    while (!hs && c < 20) begin
      @(negedge a_clk);
      if (ar_ready) hs = 1;
      tick();
      c++;
    end
    ar_valid = 1'b0;
    while (!got && c < 40) begin
      @(negedge a_clk);
      if (r_valid) begin got = 1; data = r_data; resp = r_resp; end
      tick();
      c++;
    end
    check("r_arrived", 64'(got), 64'd1);
  endtask

  // 64 back-to-back reads of every register; optional r_ready toggling 1/0 per cycle.
  task automatic burst_read(input bit toggle, input string tag);
    int  issued, rcv, c, bad, stall_bad;
    bit  done;
    issued = 0; rcv = 0; c = 0; bad = 0; stall_bad = 0; done = 0;
    while (!done && c < 400) begin
      ar_valid = (issued < N);
      ar_addr  = Base + 32'(issued * 4);
      r_ready  = toggle ? (c % 2 == 0) : 1'b1;
      @(negedge a_clk);
      if (rcv == N && !r_valid) begin
        done = 1;
        c++;
      end else begin
        if (toggle && (c % 2 == 1) && ar_valid && !ar_ready) stall_bad++;
        if (ar_valid && ar_ready) issued++;
        if (r_valid && r_ready) begin
          if (r_data !== model[rcv] || r_resp !== 2'b00) bad++;
          rcv++;
        end
        tick();
        c++;
      end
    end
    if (done) tick();
    ar_valid = 1'b0;
    r_ready  = 1'b1;
    check({tag, "_count"}, 64'(rcv), 64'(N));
    check({tag, "_data_errs"}, 64'(bad), 64'd0);
    if (toggle) check({tag, "_ar_stalls"}, 64'(stall_bad), 64'd0);
    else        check({tag, "_cycles"}, 64'(c), 64'd66);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat;
    int          lat_bad;
    int          stray;
    logic [31:0] oor [4];
    logic [31:0] old7;

    n_pass = 0; n_total = 0;
    for (int i = 0; i < N; i++) model[i] = '0;
    a_reset_n = 1'b0;
    aw_valid = 0; w_valid = 0; ar_valid = 0; b_ready = 1; r_ready = 1;
    aw_addr = '0; w_data = '0; w_strb = '0; ar_addr = '0;
    hw_wr_en = '0; hw_wr_data = '0;

    // Reset state
    repeat (3) @(posedge a_clk);
    #1;
    @(negedge a_clk);
    check("rst_aw_ready", 64'(aw_ready), 64'd0);
    check("rst_w_ready",  64'(w_ready),  64'd0);
    check("rst_ar_ready", 64'(ar_ready), 64'd0);
    check("rst_b_valid",  64'(b_valid),  64'd0);
    check("rst_r_valid",  64'(r_valid),  64'd0);
    check("rst_resps",    64'({b_resp, r_resp}), 64'd0);
    check("rst_r_data",   64'(r_data),   64'd0);
    check("rst_hw_regs",  64'(hw_regs === '0), 64'd1);
    tick();
    a_reset_n = 1'b1;
    @(negedge a_clk);
    check("rel_readies", 64'({aw_ready, w_ready, ar_ready}), 64'h7);
    tick();

    // All registers read back as zero, back to back
    burst_read(1'b0, "rd_zero");

    // Partial-strobe write, single-cycle AW->B latency
    axi_write(Base + 32'd20, 32'hDEAD_BEEF, 4'b0101, 0, 0, resp, lat);
    model[5] = 32'h00AD_00EF;
    check("strb_b_resp", 64'(resp), 64'd0);
    check("aw_to_b_lat", 64'(lat), 64'd1);
    axi_read(Base + 32'd20, rd, resp);
    check("strb_rdata", 64'(rd), 64'h00AD_00EF);
    check("strb_r_resp", 64'(resp), 64'd0);
    check("strb_hw_reg5", 64'(hw_reg(5)), 64'h00AD_00EF);
    // Sub-word address bits are ignored
    axi_read(Base + 32'd23, rd, resp);
    check("unaligned_rdata", 64'(rd), 64'h00AD_00EF);

    // Out-of-range accesses
    oor[0] = Base - 32'd4; oor[1] = Base + 32'd256; oor[2] = 32'h0; oor[3] = 32'h2000_0000;
    for (int j = 0; j < 4; j++) begin
      axi_write(oor[j], 32'hFFFF_FFFF, 4'hF, 0, 0, resp, lat);
      check("oor_b_resp", 64'(resp), 64'h3);
      axi_read(oor[j], rd, resp);
      check("oor_r_resp", 64'(resp), 64'h3);
      check("oor_r_data", 64'(rd), 64'd0);
    end
    check("oor_regs_unchanged", 64'(hw_regs === pack_model()), 64'd1);

    // Hardware load: RO register 3 takes it, RW register 4 ignores it
    hw_wr_en[3] = 1'b1; hw_wr_data[3*32 +: 32] = 32'h1234_5678;
    hw_wr_en[4] = 1'b1; hw_wr_data[4*32 +: 32] = 32'hAAAA_AAAA;
    tick();
    hw_wr_en = '0;
    model[3] = 32'h1234_5678;
    @(negedge a_clk);
    check("hw_load_ro", 64'(hw_reg(3)), 64'h1234_5678);
    check("hw_load_rw_ignored", 64'(hw_reg(4)), 64'd0);
    tick();
    axi_write(Base + 32'd12, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, lat);
    check("ro_b_resp", 64'(resp), 64'(RoResp));
    axi_read(Base + 32'd12, rd, resp);
    check("ro_rdata", 64'(rd), 64'h1234_5678);

    // Read on the same edge as a commit to the same register sees the old value
    old7 = model[7];
    aw_addr = Base + 32'd28; w_data = 32'hCAFE_F00D; w_strb = 4'hF; ar_addr = Base + 32'd28;
    aw_valid = 1; w_valid = 1; ar_valid = 1; b_ready = 1; r_ready = 1;
    @(negedge a_clk);
    check("hz_all_ready", 64'({aw_ready, w_ready, ar_ready}), 64'h7);
    tick();
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    model[7] = 32'hCAFE_F00D;
    @(negedge a_clk);
    check("hz_r_old", 64'({r_valid, r_data}), {31'd0, 1'b1, old7});
    check("hz_b", 64'({b_valid, b_resp}), 64'h4);
    tick();
    axi_read(Base + 32'd28, rd, resp);
    check("hz_r_new", 64'(rd), 64'hCAFE_F00D);

    // Every register, random data/strobes, AW vs W skew 0..3 cycles
    lat_bad = 0;
    for (int i = 0; i < N; i++) begin
      logic [31:0] d;
      logic [3:0]  s;
      int          da, dw;
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      da = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      axi_write(Base + 32'(i * 4), d, s, da, dw, resp, lat);
      if (!RoM[i]) model[i] = merge(model[i], d, s);
      check("rand_b_resp", 64'(resp), RoM[i] ? 64'(RoResp) : 64'd0);
      if (dw <= da && lat != 1) lat_bad++;
    end
    check("rand_b_latency", 64'(lat_bad), 64'd0);
    check("rand_hw_regs", 64'(hw_regs === pack_model()), 64'd1);
    burst_read(1'b1, "rd_bp");

    // Reset with a pending B, buffered AW and a full read skid
    b_ready = 0; r_ready = 0;
    aw_addr = Base + 32'd40; w_data = 32'h5555_AAAA; w_strb = 4'hF;
    aw_valid = 1; w_valid = 1;
    tick();
    aw_addr = Base + 32'd44; w_valid = 0; ar_addr = Base; ar_valid = 1;
    tick();
    aw_valid = 0;
    tick();
    @(negedge a_clk);
    check("pre_rst_b_pending", 64'(b_valid), 64'd1);
    check("pre_rst_r_pending", 64'(r_valid), 64'd1);
    check("pre_rst_skid_full", 64'(ar_ready), 64'd0);
    tick();
    a_reset_n = 0; ar_valid = 0;
    tick();
    tick();
    @(negedge a_clk);
    check("mid_rst_readies", 64'({aw_ready, w_ready, ar_ready}), 64'd0);
    tick();
    a_reset_n = 1; b_ready = 1; r_ready = 1;
    w_data = 32'h0F0F_0F0F; w_valid = 1;
    stray = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge a_clk);
      if (b_valid || r_valid) stray++;
      tick();
      w_valid = 0;
    end
    check("post_rst_no_stray", 64'(stray), 64'd0);
    check("post_rst_regs_zero", 64'(hw_regs === '0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
